// File: rtl/traffic_pkg.sv
// ----------------------------------------------------------------------------
// traffic_pkg
// Definitions shared by the traffic_light controller and its input front-end
// (input_conditioner):
//   - default board and debounce timing constants;
//   - the sample-strobe divisor calculation;
//   - the pedestrian-button supervision state encoding.
// No ports (package).
// ----------------------------------------------------------------------------
package traffic_pkg;

  // Board clock, shared with traffic_light so both blocks agree on timing.
  localparam int DEFAULT_CLK_FREQ_HZ      = 100_000_000;
  // Debounce sampling rate (one strobe per millisecond by default).
  localparam int DEFAULT_SAMPLE_HZ        = 1_000;
  // Consecutive disagreeing samples before a debounced level changes.
  localparam int DEFAULT_DEBOUNCE_SAMPLES = 8;
  // Samples the button may stay pressed before it is reported stuck.
  localparam int DEFAULT_STUCK_SAMPLES    = 30_000;

  // Widths of the internal counters.
  localparam int DIV_CNT_W  = 32;
  localparam int DEB_CNT_W  = 8;
  localparam int HOLD_CNT_W = 20;

  // Pedestrian-button supervision states.
  typedef enum logic [1:0] {
    BTN_IDLE  = 2'd0,
    BTN_HELD  = 2'd1,
    BTN_STUCK = 2'd2
  } btn_state_t;

  // Clock cycles per debounce sample. The caller must keep the result >= 2.
  function automatic int calc_divisor(input int clk_hz, input int sample_hz);
    return clk_hz / sample_hz;
  endfunction

endpackage : traffic_pkg

// File: rtl/debounce_filter.sv
// ----------------------------------------------------------------------------
// debounce_filter
// Debounces one already-synchronized input. The input is looked at only on
// sample strobes. The debounced level flips after DEBOUNCE_SAMPLES
// consecutive samples that disagree with it. Any agreeing sample restarts
// the count.
//
// Ports:
//   clk       in   1  clock, rising edge
//   reset     in   1  asynchronous active-low reset
//   strobe    in   1  one-cycle sample strobe
//   din_sync  in   1  synchronized raw input
//   dout      out  1  debounced level (registered)
// ----------------------------------------------------------------------------
module debounce_filter
  import traffic_pkg::*;
#(
  parameter int DEBOUNCE_SAMPLES = DEFAULT_DEBOUNCE_SAMPLES
) (
  input  logic clk,
  input  logic reset,
  input  logic strobe,
  input  logic din_sync,
  output logic dout
);

  // Value of cnt_r at which the next disagreeing sample completes the run.
  localparam logic [DEB_CNT_W-1:0] CNT_LAST = DEB_CNT_W'(DEBOUNCE_SAMPLES - 1);

  logic [DEB_CNT_W-1:0] cnt_r;
  logic                 stable_r;

  // Count consecutive disagreeing samples and flip the stable level at the end of the run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r    <= {DEB_CNT_W{1'b0}};
      stable_r <= 1'b0;
    end else if (strobe) begin
      if (din_sync != stable_r) begin
        // cnt_r holds the disagreeing samples already seen. This sample
        // completes the run when cnt_r has reached CNT_LAST.
        if (cnt_r == CNT_LAST) begin
          stable_r <= din_sync;
          cnt_r    <= {DEB_CNT_W{1'b0}};
        end else begin
          cnt_r    <= cnt_r + {{(DEB_CNT_W-1){1'b0}}, 1'b1};
        end
      end else begin
        cnt_r <= {DEB_CNT_W{1'b0}};
      end
    end else begin
      cnt_r    <= cnt_r;
      stable_r <= stable_r;
    end
  end

  assign dout = stable_r;

endmodule : debounce_filter

// File: rtl/input_conditioner.sv
// ----------------------------------------------------------------------------
// input_conditioner
// Front-end for traffic_light. It synchronizes and debounces the raw
// pedestrian button and the raw maintenance key-switch. It then produces:
//   - a clean maintenance level;
//   - a latched pedestrian request, cleared by the controller's acknowledge;
//   - a stuck-button fault flag;
//   - a saturating count of accepted presses.
//
// Ports:
//   clk           in   1  board clock, rising edge
//   reset         in   1  asynchronous active-low reset
//   ped_btn_raw   in   1  raw pedestrian button (asynchronous, active-high)
//   maint_sw_raw  in   1  raw maintenance switch (asynchronous, active-high)
//   ped_ack       in   1  one-cycle walk-granted pulse from the controller
//   MAINT         out  1  debounced maintenance level
//   ped_req       out  1  latched pedestrian request
//   btn_fault     out  1  button held beyond STUCK_SAMPLES samples
//   ped_count     out  8  saturating count of accepted presses
// ----------------------------------------------------------------------------
module input_conditioner
  import traffic_pkg::*;
#(
  parameter int CLK_FREQ_HZ      = DEFAULT_CLK_FREQ_HZ,
  parameter int SAMPLE_HZ        = DEFAULT_SAMPLE_HZ,
  parameter int DEBOUNCE_SAMPLES = DEFAULT_DEBOUNCE_SAMPLES,
  parameter int STUCK_SAMPLES    = DEFAULT_STUCK_SAMPLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_btn_raw,
  input  logic       maint_sw_raw,
  input  logic       ped_ack,
  output logic       MAINT,
  output logic       ped_req,
  output logic       btn_fault,
  output logic [7:0] ped_count
);

  localparam int DIVISOR = calc_divisor(CLK_FREQ_HZ, SAMPLE_HZ);
  localparam logic [DIV_CNT_W-1:0]  DIV_LAST  = DIV_CNT_W'(DIVISOR - 1);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LAST = HOLD_CNT_W'(STUCK_SAMPLES - 1);

  // Synchronizer stages.
  logic btn_meta_r;
  logic btn_sync_r;
  logic maint_meta_r;
  logic maint_sync_r;

  // Sample strobe.
  logic [DIV_CNT_W-1:0] div_cnt_r;
  logic                 strobe_s;

  // Debounced levels.
  logic btn_stable_s;
  logic maint_stable_s;

  // Button supervision.
  btn_state_t             btn_state_r;
  logic [HOLD_CNT_W-1:0]  hold_cnt_r;
  logic                   btn_fault_r;
  logic                   pressed_evt_s;

  // Request latch.
  logic       ped_req_r;
  logic [7:0] ped_count_r;

  // Two-flop synchronizers for both raw asynchronous inputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_meta_r   <= 1'b0;
      btn_sync_r   <= 1'b0;
      maint_meta_r <= 1'b0;
      maint_sync_r <= 1'b0;
    end else begin
      btn_meta_r   <= ped_btn_raw;
      btn_sync_r   <= btn_meta_r;
      maint_meta_r <= maint_sw_raw;
      maint_sync_r <= maint_meta_r;
    end
  end

  // The strobe is high for the single cycle in which the divider sits at its last count.
  assign strobe_s = (div_cnt_r == DIV_LAST);

  // Free-running sample divider, 0..DIVISOR-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_r <= {DIV_CNT_W{1'b0}};
    end else if (strobe_s) begin
      div_cnt_r <= {DIV_CNT_W{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_r + {{(DIV_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  debounce_filter #(
    .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES)
  ) u_btn_filter (
    .clk      (clk),
    .reset    (reset),
    .strobe   (strobe_s),
    .din_sync (btn_sync_r),
    .dout     (btn_stable_s)
  );

  debounce_filter #(
    .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES)
  ) u_maint_filter (
    .clk      (clk),
    .reset    (reset),
    .strobe   (strobe_s),
    .din_sync (maint_sync_r),
    .dout     (maint_stable_s)
  );

  // The FSM only returns to BTN_IDLE once the stable level is low. Seeing
  // a high level while idle therefore means a fresh debounced rise. That
  // cycle is the single-cycle press event.
  assign pressed_evt_s = (btn_state_r == BTN_IDLE) && btn_stable_s;

  // Button supervision: press detection, hold timing and stuck flagging.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_state_r <= BTN_IDLE;
      hold_cnt_r  <= {HOLD_CNT_W{1'b0}};
      btn_fault_r <= 1'b0;
    end else begin
      case (btn_state_r)
        BTN_IDLE: begin
          btn_fault_r <= 1'b0;
          if (btn_stable_s) begin
            btn_state_r <= BTN_HELD;
            hold_cnt_r  <= {HOLD_CNT_W{1'b0}};
          end else begin
            btn_state_r <= BTN_IDLE;
          end
        end
        BTN_HELD: begin
          if (!btn_stable_s) begin
            btn_state_r <= BTN_IDLE;
          end else if (strobe_s) begin
            if (hold_cnt_r == HOLD_LAST) begin
              btn_state_r <= BTN_STUCK;
              btn_fault_r <= 1'b1;
            end else begin
              hold_cnt_r <= hold_cnt_r + {{(HOLD_CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            btn_state_r <= BTN_HELD;
          end
        end
        BTN_STUCK: begin
          // hold_cnt_r is frozen here, so it never wraps on a long hold.
          if (!btn_stable_s) begin
            btn_state_r <= BTN_IDLE;
            btn_fault_r <= 1'b0;
          end else begin
            btn_state_r <= BTN_STUCK;
            btn_fault_r <= 1'b1;
          end
        end
        default: begin
          btn_state_r <= BTN_IDLE;
          hold_cnt_r  <= {HOLD_CNT_W{1'b0}};
          btn_fault_r <= 1'b0;
        end
      endcase
    end
  end

  // Request latch and press counter. Maintenance overrides everything.
  // A press beats a simultaneous acknowledge, so no press is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ped_req_r   <= 1'b0;
      ped_count_r <= 8'd0;
    end else if (maint_stable_s) begin
      ped_req_r   <= 1'b0;
    end else if (pressed_evt_s) begin
      ped_req_r   <= 1'b1;
      if (ped_count_r != 8'hFF) begin
        ped_count_r <= ped_count_r + 8'd1;
      end else begin
        ped_count_r <= ped_count_r;
      end
    end else if (ped_ack) begin
      ped_req_r   <= 1'b0;
    end else begin
      ped_req_r   <= ped_req_r;
    end
  end

  assign MAINT     = maint_stable_s;
  assign ped_req   = ped_req_r;
  assign btn_fault = btn_fault_r;
  assign ped_count = ped_count_r;

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with DIVISOR=10,
// DEBOUNCE_SAMPLES=3 and STUCK_SAMPLES=5. The expected press counts go
// into a queue when a press is driven. They are popped and compared once
// the request appears, or once the observation window closes.
module tb_input_conditioner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ped_btn_raw = 1'b0;
  logic       maint_sw_raw = 1'b0;
  logic       ped_ack = 1'b0;
  logic       MAINT;
  logic       ped_req;
  logic       btn_fault;
  logic [7:0] ped_count;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_count = 8'd0;

  input_conditioner #(
    .CLK_FREQ_HZ      (100),
    .SAMPLE_HZ        (10),
    .DEBOUNCE_SAMPLES (3),
    .STUCK_SAMPLES    (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ped_btn_raw  (ped_btn_raw),
    .maint_sw_raw (maint_sw_raw),
    .ped_ack      (ped_ack),
    .MAINT        (MAINT),
    .ped_req      (ped_req),
    .btn_fault    (btn_fault),
    .ped_count    (ped_count)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_count(input string name);
    logic [7:0] exp_v;
    exp_v = exp_q.pop_front();
    vectors++;
    if (ped_count !== exp_v) begin
      miscompares++;
      $display("FAIL %s: ped_count got %0d expected %0d", name, ped_count, exp_v);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(2);
    vectors++;
    if ({MAINT, ped_req, btn_fault} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_flags: got %b expected 000", {MAINT, ped_req, btn_fault});
    end
    exp_q.push_back(8'd0);
    pop_count("reset_count");
    reset = 1'b1;
    tick(1);
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 15; i++) begin
      ped_btn_raw = (i % 2 == 0);
      tick(7);
      vectors++;
      if (ped_req !== 1'b0 || ped_count !== 8'd0) begin
        miscompares++;
        $display("FAIL bounce_%0d: req=%b count=%0d expected req=0 count=0", i, ped_req, ped_count);
      end
    end
    ped_btn_raw = 1'b0;
    tick(50);
    vectors++;
    if (ped_req !== 1'b0 || ped_count !== 8'd0) begin
      miscompares++;
      $display("FAIL bounce_settle: req=%b count=%0d expected req=0 count=0", ped_req, ped_count);
    end
  endtask

  task automatic test_clean_press();
    int used;
    model_count++;
    exp_q.push_back(model_count);
    ped_btn_raw = 1'b1;
    used = 0;
    while (ped_req !== 1'b1 && used < 33) begin
      tick(1);
      used++;
    end
    vectors++;
    if (ped_req !== 1'b1) begin
      miscompares++;
      $display("FAIL press_latency: ped_req got %b expected 1 within 33 clk", ped_req);
    end
    pop_count("press_count");
    tick(60 - used);
    ped_ack = 1'b1;
    tick(1);
    ped_ack = 1'b0;
    vectors++;
    if (ped_req !== 1'b0) begin
      miscompares++;
      $display("FAIL press_ack: ped_req got %b expected 0", ped_req);
    end
    ped_btn_raw = 1'b0;
    tick(50);
    vectors++;
    if (ped_req !== 1'b0 || btn_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL press_release: req=%b fault=%b expected 0 0", ped_req, btn_fault);
    end
  endtask

  task automatic test_simultaneous();
    int used;
    model_count++;
    exp_q.push_back(model_count);
    ped_btn_raw = 1'b1;
    used = 0;
    while (ped_req !== 1'b1 && used < 33) begin
      tick(1);
      used++;
    end
    pop_count("simul_first_count");
    ped_btn_raw = 1'b0;
    tick(50);
    vectors++;
    if (ped_req !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_pending: ped_req got %b expected 1", ped_req);
    end
    model_count++;
    exp_q.push_back(model_count);
    ped_btn_raw = 1'b1;
    used = 0;
    while (dut.pressed_evt_s !== 1'b1 && used < 33) begin
      tick(1);
      used++;
    end
    vectors++;
    if (dut.pressed_evt_s !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_evt_timeout: press event got %b expected 1 within 33 clk", dut.pressed_evt_s);
    end
    ped_ack = 1'b1;
    tick(1);
    ped_ack = 1'b0;
    vectors++;
    if (ped_req !== 1'b1) begin
      miscompares++;
      $display("FAIL simul_req: ped_req got %b expected 1", ped_req);
    end
    pop_count("simul_count");
    ped_btn_raw = 1'b0;
    tick(50);
  endtask

  task automatic test_maintenance();
    int used;
    maint_sw_raw = 1'b1;
    used = 0;
    while (MAINT !== 1'b1 && used < 32) begin
      tick(1);
      used++;
    end
    vectors++;
    if (MAINT !== 1'b1) begin
      miscompares++;
      $display("FAIL maint_on: MAINT got %b expected 1 within 32 clk", MAINT);
    end
    tick(1);
    vectors++;
    if (ped_req !== 1'b0) begin
      miscompares++;
      $display("FAIL maint_clear_req: ped_req got %b expected 0", ped_req);
    end
    exp_q.push_back(model_count);
    ped_btn_raw = 1'b1;
    tick(40);
    ped_btn_raw = 1'b0;
    tick(50);
    vectors++;
    if (ped_req !== 1'b0) begin
      miscompares++;
      $display("FAIL maint_press_req: ped_req got %b expected 0", ped_req);
    end
    pop_count("maint_press_count");
    maint_sw_raw = 1'b0;
    used = 0;
    while (MAINT !== 1'b0 && used < 32) begin
      tick(1);
      used++;
    end
    vectors++;
    if (MAINT !== 1'b0) begin
      miscompares++;
      $display("FAIL maint_off: MAINT got %b expected 0 within 32 clk", MAINT);
    end
  endtask

  task automatic test_stuck();
    int used;
    int held;
    model_count++;
    exp_q.push_back(model_count);
    ped_btn_raw = 1'b1;
    used = 0;
    while (ped_req !== 1'b1 && used < 33) begin
      tick(1);
      used++;
    end
    vectors++;
    if (ped_req !== 1'b1) begin
      miscompares++;
      $display("FAIL stuck_req: ped_req got %b expected 1", ped_req);
    end
    pop_count("stuck_count");
    held = used;
    tick(39);
    held += 39;
    vectors++;
    if (btn_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL stuck_early: btn_fault got %b expected 0 before 5 strobes", btn_fault);
    end
    used = 0;
    while (btn_fault !== 1'b1 && used < 12) begin
      tick(1);
      used++;
    end
    held += used;
    vectors++;
    if (btn_fault !== 1'b1) begin
      miscompares++;
      $display("FAIL stuck_fault: btn_fault got %b expected 1", btn_fault);
    end
    if (held < 150) tick(150 - held);
    vectors++;
    if (ped_req !== 1'b1 || ped_count !== model_count) begin
      miscompares++;
      $display("FAIL stuck_once: req=%b count=%0d expected req=1 count=%0d", ped_req, ped_count, model_count);
    end
    ped_btn_raw = 1'b0;
    used = 0;
    while (btn_fault !== 1'b0 && used < 34) begin
      tick(1);
      used++;
    end
    vectors++;
    if (btn_fault !== 1'b0) begin
      miscompares++;
      $display("FAIL stuck_release: btn_fault got %b expected 0", btn_fault);
    end
    ped_ack = 1'b1;
    tick(1);
    ped_ack = 1'b0;
    tick(5);
    model_count++;
    exp_q.push_back(model_count);
    ped_btn_raw = 1'b1;
    used = 0;
    while (ped_req !== 1'b1 && used < 33) begin
      tick(1);
      used++;
    end
    vectors++;
    if (ped_req !== 1'b1) begin
      miscompares++;
      $display("FAIL stuck_repress: ped_req got %b expected 1", ped_req);
    end
    pop_count("stuck_repress_count");
  endtask

  task automatic test_reset_midop();
    int used;
    tick(60);
    maint_sw_raw = 1'b1;
    used = 0;
    while (MAINT !== 1'b1 && used < 32) begin
      tick(1);
      used++;
    end
    vectors++;
    if ({MAINT, ped_req, btn_fault} !== 3'b111) begin
      miscompares++;
      $display("FAIL midop_setup: MAINT/req/fault got %b expected 111", {MAINT, ped_req, btn_fault});
    end
    #1;
    reset = 1'b0;
    #1;
    vectors++;
    if ({MAINT, ped_req, btn_fault} !== 3'b000 || ped_count !== 8'd0) begin
      miscompares++;
      $display("FAIL midop_async: flags=%b count=%0d expected 000 0", {MAINT, ped_req, btn_fault}, ped_count);
    end
    ped_btn_raw  = 1'b0;
    maint_sw_raw = 1'b0;
    model_count  = 8'd0;
    tick(2);
    reset = 1'b1;
    exp_q.push_back(model_count);
    tick(40);
    vectors++;
    if ({MAINT, ped_req, btn_fault} !== 3'b000) begin
      miscompares++;
      $display("FAIL midop_after: flags=%b expected 000", {MAINT, ped_req, btn_fault});
    end
    pop_count("midop_count");
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_press();
    test_simultaneous();
    test_maintenance();
    test_stuck();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_input_conditioner
